// File: rtl/systolic_sched_pkg.sv
// Shared types and helpers for the systolic tile sequencer.
package systolic_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_SETTLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } sched_state_e;

    function automatic int drain_cycles(int n_rows, int n_cols, int pipe);
        return (n_rows - 1) + (n_cols - 1) + pipe;
    endfunction

    // Thermometer mask, low bits set; 0 or oversize clamps to all rows.
    function automatic logic [63:0] row_mask(int rows, int n_rows);
        int r;
        logic [63:0] m;
        r = (rows == 0 || rows > n_rows) ? n_rows : rows;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            m[i] = (i < r);
        end
        return m;
    endfunction

endpackage

// File: rtl/systolic_tile_sched_cnt.sv
// Loadable down-counter with zero flag; shared by settle, beat and drain.
module sched_down_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/systolic_tile_sched.sv
// Tile sequencer: clear, weight load, settle, stream, drain, done.
module systolic_tile_sched
    import systolic_sched_pkg::*;
#(
    parameter int N_ROWS = 14,
    parameter int N_COLS = 14,
    parameter int PIPE   = 1,
    parameter int K_W    = 16,
    parameter int ROW_W  = $clog2(N_ROWS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [K_W-1:0]    cfg_k_len,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic              wgt_valid,
    output logic              wgt_ready,
    input  logic              act_valid,
    output logic              act_ready,
    output logic              sa_en,
    output logic              sa_clr,
    output logic              sa_load_weight,
    output logic [N_ROWS-1:0] sa_row_en,
    output logic              sa_a_zero,
    output logic              busy,
    output logic              done,
    output logic [K_W-1:0]    stall_cnt
);

    localparam int D  = drain_cycles(N_ROWS, N_COLS, PIPE);
    localparam int DW = $clog2(D + 1);
    localparam int SW = $clog2(N_COLS + 1);
    localparam int MW = (DW > SW) ? DW : SW;
    localparam int CW = (K_W > MW) ? K_W : MW;

    sched_state_e      state;
    logic [K_W-1:0]    k_len_q;
    logic [N_ROWS-1:0] mask_q;
    logic [K_W-1:0]    stall_q;

    logic          cnt_load;
    logic          cnt_dec;
    logic [CW-1:0] cnt_val;
    logic          cnt_zero;

    sched_down_cnt #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Each phase preloads the next phase's length minus one.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        unique case (1'b1)
            state == S_LOAD: begin
                cnt_load = wgt_valid;
                cnt_val  = CW'(N_COLS - 1);
            end
            state == S_SETTLE: begin
                cnt_load = cnt_zero;
                cnt_dec  = !cnt_zero;
                cnt_val  = CW'(k_len_q) - CW'(1);
            end
            state == S_STREAM: begin
                cnt_load = act_valid && cnt_zero;
                cnt_dec  = act_valid && !cnt_zero;
                cnt_val  = CW'(D - 1);
            end
            state == S_DRAIN: begin
                cnt_dec = !cnt_zero;
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            k_len_q <= '0;
            mask_q  <= '0;
            stall_q <= '0;
        end else if (abort) begin
            state  <= S_IDLE;
            mask_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        k_len_q <= cfg_k_len;
                        mask_q  <= N_ROWS'(row_mask(int'(cfg_rows), N_ROWS));
                        stall_q <= '0;
                        state   <= S_CLR;
                    end
                end
                S_CLR: state <= S_LOAD;
                S_LOAD: begin
                    if (wgt_valid) state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_zero)
                        state <= (k_len_q == '0) ? S_DONE : S_STREAM;
                end
                S_STREAM: begin
                    if (!act_valid && stall_q != '1)
                        stall_q <= stall_q + K_W'(1);
                    if (act_valid && cnt_zero) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (cnt_zero) state <= S_DONE;
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    mask_q <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready      = (state == S_IDLE);
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign sa_clr         = (state == S_CLR);
    assign wgt_ready      = (state == S_LOAD);
    assign sa_load_weight = (state == S_LOAD) && wgt_valid;
    assign act_ready      = (state == S_STREAM);
    assign sa_a_zero      = (state == S_DRAIN);
    assign sa_en          = ((state == S_STREAM) && act_valid)
                          || (state == S_DRAIN);
    assign sa_row_en      = mask_q;
    assign stall_cnt      = stall_q;

endmodule
